alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares the single 8-bit ALU datapath (op_start, operation, operand_a, operand_b, result) between NUM_REQ requesters.
- Round-robin arbitration.
- For the granted requester: latches its operands, issues one op_start pulse, waits the fixed ALU latency, captures result, returns it with a one-cycle valid pulse.
- Sits between requester blocks and the ALU; the only driver of the ALU inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ALU_LAT, 3, cycles from op_start-high cycle to cycle in which alu_result is valid (>=1)
ID_W, $clog2(NUM_REQ), requester index width

Ports:
clk  in  1  clock, all flops on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request level; held with payload until gnt
req_op  in  2*NUM_REQ  per-requester operation, slice i = [2i+1:2i]
req_a  in  8*NUM_REQ  per-requester operand_a, slice i = [8i+7:8i]
req_b  in  8*NUM_REQ  per-requester operand_b
gnt  out  NUM_REQ  one-hot one-cycle accept pulse
rsp_valid  out  NUM_REQ  one-hot one-cycle response pulse
rsp_result  out  16  captured ALU result, valid when any rsp_valid bit set
rsp_id  out  ID_W  index of requester owning rsp_result
op_start  out  1  ALU start pulse
operation  out  2  to ALU
operand_a  out  8  to ALU
operand_b  out  8  to ALU
alu_result  in  16  from ALU result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, ptr=0, all outputs 0 (gnt, rsp_valid, rsp_result, rsp_id, op_start, operation, operand_a/b, busy). Reset mid-operation aborts the transaction; no rsp_valid is ever produced for it.
- All outputs registered.
- Arbitration: winner w = first i with req[i]=1, searching ptr, ptr+1, ... wrapping mod NUM_REQ. On grant, ptr <= (w+1) mod NUM_REQ. ptr is unchanged when there is no grant.
- States:
  - IDLE: if any req, latch w, req_op/a/b slices of w -> ISSUE. Else stay in IDLE.
  - ISSUE (1 cycle, cycle C): gnt[w]=1, op_start=1, operation/operand_a/operand_b = latched values; load cnt=ALU_LAT -> WAIT.
  - WAIT: cnt decrements each cycle. Operand outputs hold latched values; op_start=0. On the cycle where cnt==1 (cycle C+ALU_LAT), sample alu_result into rsp_result at the end of the cycle -> RESP.
  - RESP (cycle C+ALU_LAT+1): rsp_valid[w]=1, rsp_id=w. If any req this cycle, arbitrate (new ptr) and latch -> ISSUE. Else -> IDLE.
- Back-to-back issue period = ALU_LAT+2 cycles. Idle-to-first op_start = 1 cycle after req sampled.
- Requester may drop req the cycle after gnt. If req is still high in RESP or later, it is a new request.
- A req that drops before gnt is withdrawn without side effect.
- A request arriving during ISSUE/WAIT waits; it is never lost while held.
- operation is passed through unchanged; the block does not interpret it.
- rsp_result/rsp_id hold their value after RESP until the next capture.
- Operand outputs hold their last value in IDLE.

Test Plan:
1. Reset: rst_n=0 mid-WAIT with req[1]=1 -> all outputs 0 asynchronously; after release no rsp_valid for the aborted op; req[1] re-granted, ptr starts at 0.
2. Single op: NUM_REQ=4, ALU_LAT=3, req[2]=1 with op=2'b01, a=8'd3, b=8'd4; ALU stub drives 16'hA5A5 only in cycle C+3 -> op_start/gnt[2] at cycle C with operand_a=3, operand_b=4, operation=01; rsp_valid=4'b0100, rsp_result=16'hA5A5, rsp_id=2 at C+4; exactly one op_start.
3. Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0 with op_start spacing 5 cycles; each rsp_valid maps to the matching slice's operands.
4. Wrap and skip: ptr=3, req=4'b0101 -> grant 0 then 2; ptr after = 3.
5. Late arrival: req[1] asserted during WAIT of req[0] -> req[1] issued directly from RESP (op_start at C+5), busy stays high throughout.
6. Withdrawal: req[3] pulsed for one cycle while busy and dropped before RESP -> never granted, no rsp_valid[3]; returns to IDLE, busy=0.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one fixed-latency 8-bit ALU among
// NUM_REQ requesters: latch, issue, wait ALU_LAT cycles, return result.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_op,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [15:0]          rsp_result,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 op_start,
    output logic [1:0]           operation,
    output logic [7:0]           operand_a,
    output logic [7:0]           operand_b,
    input  logic [15:0]          alu_result,
    output logic                 busy
);

    localparam int CNT_W = $clog2(ALU_LAT + 1);
    localparam logic [NUM_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    win_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [15:0]        rsp_result_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               op_start_q;
    logic [1:0]         operation_q;
    logic [7:0]         operand_a_q;
    logic [7:0]         operand_b_q;
    logic               busy_q;

    logic [ID_W-1:0]    win_d;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    idx;
    logic               any_req;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_d = ptr_q;
        idx   = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req[idx]) begin
                win_d = idx;
            end
        end
    end

    assign any_req = |req;
    assign ptr_d   = (win_d == ID_W'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            op_start_q   <= 1'b0;
            operation_q  <= '0;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            gnt_q       <= '0;
            op_start_q  <= 1'b0;
            rsp_valid_q <= '0;
            unique case (state_q)
                IDLE, RESP: begin
                    if (any_req) begin
                        win_q       <= win_d;
                        ptr_q       <= ptr_d;
                        gnt_q       <= ONE << win_d;
                        op_start_q  <= 1'b1;
                        operation_q <= req_op[{win_d, 1'b0} +: 2];
                        operand_a_q <= req_a[{win_d, 3'b000} +: 8];
                        operand_b_q <= req_b[{win_d, 3'b000} +: 8];
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_W'(ALU_LAT);
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_result_q <= alu_result;
                        rsp_valid_q  <= ONE << win_q;
                        rsp_id_q     <= win_q;
                        state_q      <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign op_start   = op_start_q;
    assign operation  = operation_q;
    assign operand_a  = operand_a_q;
    assign operand_b  = operand_b_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a fixed-latency ALU stub
// and per-scenario tasks that check issue/response timing and data.
module tb_alu_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ALU_LAT = 3;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_op;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [15:0]          rsp_result;
    logic [ID_W-1:0]      rsp_id;
    logic                 op_start;
    logic [1:0]           operation;
    logic [7:0]           operand_a;
    logic [7:0]           operand_b;
    logic [15:0]          alu_result;
    logic                 busy;

    logic [1:0]  op_v    [NUM_REQ];
    logic [7:0]  a_v     [NUM_REQ];
    logic [7:0]  b_v     [NUM_REQ];
    logic [15:0] exp_res [NUM_REQ];

    int   tests;
    int   fails;
    int   cyc;
    logic auto_drop;
    logic fixed_en;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [3:0]  v;
        logic [1:0]  id;
        logic [15:0] res;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    int        s_cnt;
    logic [1:0] s_op;
    logic [7:0] s_a;
    logic [7:0] s_b;

    alu_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .rsp_id    (rsp_id),
        .op_start  (op_start),
        .operation (operation),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .alu_result(alu_result),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[2*i +: 2] = op_v[i];
            req_a[8*i +: 8]  = a_v[i];
            req_b[8*i +: 8]  = b_v[i];
        end
    end

    // ALU stub: result is only non-zero in the cycle ALU_LAT after op_start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt <= 0;
            s_op  <= '0;
            s_a   <= '0;
            s_b   <= '0;
        end else if (op_start) begin
            s_cnt <= ALU_LAT;
            s_op  <= operation;
            s_a   <= operand_a;
            s_b   <= operand_b;
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
        end
    end

    always_comb begin
        alu_result = 16'h0000;
        if (s_cnt == 1) begin
            alu_result = fixed_en ? 16'hA5A5 : ({s_a, s_b} ^ {14'b0, s_op});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    task automatic set_table();
        op_v[0] = 2'd0; a_v[0] = 8'h13; b_v[0] = 8'h81; exp_res[0] = 16'h1381;
        op_v[1] = 2'd1; a_v[1] = 8'h27; b_v[1] = 8'h92; exp_res[1] = 16'h2793;
        op_v[2] = 2'd2; a_v[2] = 8'h3A; b_v[2] = 8'hA3; exp_res[2] = 16'h3AA1;
        op_v[3] = 2'd3; a_v[3] = 8'h4C; b_v[3] = 8'hB4; exp_res[3] = 16'h4CB7;
    endtask

    // Advance to the next falling edge and log issue/response events.
    task automatic step();
        iss_t ie;
        rsp_t re;
        @(negedge clk);
        cyc++;
        if (op_start) begin
            ie.cyc = cyc; ie.gnt = gnt; ie.op = operation;
            ie.a = operand_a; ie.b = operand_b;
            iss_q.push_back(ie);
        end
        if (|rsp_valid) begin
            re.cyc = cyc; re.v = rsp_valid; re.id = rsp_id; re.res = rsp_result;
            rsp_q.push_back(re);
        end
        if (auto_drop) req = req & ~gnt;
    endtask

    task automatic test_reset();
        logic [45:0] outs;
        rst_n = 1'b1;
        req = '0;
        #1 rst_n = 1'b0;
        step();
        step();
        outs = {gnt, rsp_valid, rsp_result, rsp_id, op_start,
                operation, operand_a, operand_b, busy};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h required 0", outs);
        end
        rst_n = 1'b1;
        auto_drop = 1'b0;
        req = 4'b0010;
        step();
        step();
        step();
        tests++;
        if (iss_q.size() != 1 || iss_q[0].gnt !== 4'b0010 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_issue: issues=%0d busy=%b required 1 issue busy=1",
                     iss_q.size(), busy);
        end
        #2 rst_n = 1'b0;
        #1;
        outs = {gnt, rsp_valid, rsp_result, rsp_id, op_start,
                operation, operand_a, operand_b, busy};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_async: got %h required 0", outs);
        end
        req = 4'b1010;
        step();
        step();
        iss_q.delete();
        rsp_q.delete();
        rst_n = 1'b1;
        for (int k = 0; k < 10 && iss_q.size() == 0; k++) step();
        req = '0;
        tests++;
        if (iss_q.size() != 1 || iss_q[0].gnt !== 4'b0010 || iss_q[0].a !== 8'h27) begin
            fails++;
            $display("FAIL reset_regrant: issues=%0d gnt=%b required 1 issue gnt=0010",
                     iss_q.size(), (iss_q.size() > 0) ? iss_q[0].gnt : 4'b0);
        end
        for (int k = 0; k < 12; k++) step();
        tests++;
        if (rsp_q.size() != 1 || rsp_q[0].v !== 4'b0010 ||
            rsp_q[0].res !== exp_res[1] || rsp_q[0].cyc != iss_q[0].cyc + 4) begin
            fails++;
            $display("FAIL reset_no_stale_rsp: rsps=%0d required exactly 1 at issue+4",
                     rsp_q.size());
        end
    endtask

    task automatic test_single();
        int c0;
        auto_drop = 1'b1;
        fixed_en = 1'b1;
        op_v[2] = 2'b01; a_v[2] = 8'd3; b_v[2] = 8'd4;
        iss_q.delete();
        rsp_q.delete();
        c0 = cyc;
        req = 4'b0100;
        for (int k = 0; k < 12 && rsp_q.size() == 0; k++) step();
        if (rsp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL single_timeout: no rsp_valid required one");
        end
        step();
        tests++;
        if (iss_q.size() != 1 || iss_q[0].cyc != c0 + 1) begin
            fails++;
            $display("FAIL single_issue_count: issues=%0d required 1 at cycle %0d",
                     iss_q.size(), c0 + 1);
        end
        tests++;
        if (iss_q.size() < 1 || iss_q[0].gnt !== 4'b0100 || iss_q[0].op !== 2'b01 ||
            iss_q[0].a !== 8'd3 || iss_q[0].b !== 8'd4) begin
            fails++;
            $display("FAIL single_issue_data: gnt/op/a/b wrong required 0100/01/3/4");
        end
        tests++;
        if (rsp_q.size() != 1 || rsp_q[0].v !== 4'b0100 || rsp_q[0].id !== 2'd2 ||
            rsp_q[0].res !== 16'hA5A5 || rsp_q[0].cyc != iss_q[0].cyc + 4) begin
            fails++;
            $display("FAIL single_rsp: res=%h required a5a5 id 2 at issue+4",
                     (rsp_q.size() > 0) ? rsp_q[0].res : 16'h0);
        end
        tests++;
        if (busy !== 1'b0 || rsp_result !== 16'hA5A5 || rsp_id !== 2'd2) begin
            fails++;
            $display("FAIL single_hold: busy=%b res=%h required busy 0 res a5a5",
                     busy, rsp_result);
        end
        fixed_en = 1'b0;
        set_table();
    endtask

    task automatic test_wrap_skip();
        auto_drop = 1'b1;
        iss_q.delete();
        rsp_q.delete();
        req = 4'b0101;
        for (int k = 0; k < 30 && rsp_q.size() < 2; k++) step();
        tests++;
        if (iss_q.size() != 2 || iss_q[0].gnt !== 4'b0001 || iss_q[1].gnt !== 4'b0100 ||
            iss_q[1].cyc != iss_q[0].cyc + 5) begin
            fails++;
            $display("FAIL wrap_order: issues=%0d required grant 0 then 2 spaced 5",
                     iss_q.size());
        end
        tests++;
        if (rsp_q.size() != 2 || rsp_q[0].res !== exp_res[0] || rsp_q[1].res !== exp_res[2]) begin
            fails++;
            $display("FAIL wrap_rsp: rsps=%0d required 2 with %h %h",
                     rsp_q.size(), exp_res[0], exp_res[2]);
        end
        step();
        step();
        iss_q.delete();
        rsp_q.delete();
        req = 4'b1100;
        for (int k = 0; k < 10 && iss_q.size() == 0; k++) step();
        req = '0;
        tests++;
        if (iss_q.size() != 1 || iss_q[0].gnt !== 4'b1000) begin
            fails++;
            $display("FAIL wrap_ptr_after: gnt=%b required 1000",
                     (iss_q.size() > 0) ? iss_q[0].gnt : 4'b0);
        end
        for (int k = 0; k < 10 && rsp_q.size() == 0; k++) step();
        step();
    endtask

    task automatic test_withdrawal();
        int idle_cyc;
        auto_drop = 1'b1;
        iss_q.delete();
        rsp_q.delete();
        req = 4'b0001;
        for (int k = 0; k < 10 && iss_q.size() == 0; k++) step();
        step();
        req = req | 4'b1000;
        step();
        req = '0;
        idle_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
        end
        tests++;
        if (iss_q.size() < 1 || idle_cyc != iss_q[0].cyc + 5) begin
            fails++;
            $display("FAIL withdraw_idle: idle at %0d required %0d",
                     idle_cyc, (iss_q.size() > 0) ? iss_q[0].cyc + 5 : -1);
        end
        for (int k = 0; k < 8; k++) step();
        tests++;
        if (iss_q.size() != 1 || rsp_q.size() != 1 || rsp_q[0].v !== 4'b0001 ||
            busy !== 1'b0) begin
            fails++;
            $display("FAIL withdraw_never_granted: issues=%0d rsps=%0d required 1 and 1",
                     iss_q.size(), rsp_q.size());
        end
    endtask

    task automatic test_late_arrival();
        logic busy_drop;
        auto_drop = 1'b1;
        busy_drop = 1'b0;
        iss_q.delete();
        rsp_q.delete();
        req = 4'b0001;
        for (int k = 0; k < 30 && rsp_q.size() < 2; k++) begin
            step();
            if (iss_q.size() >= 1 && !busy) busy_drop = 1'b1;
            if (iss_q.size() == 1 && cyc == iss_q[0].cyc + 1) req = req | 4'b0010;
        end
        tests++;
        if (iss_q.size() != 2 || iss_q[0].gnt !== 4'b0001 || iss_q[1].gnt !== 4'b0010 ||
            iss_q[1].cyc != iss_q[0].cyc + 5) begin
            fails++;
            $display("FAIL late_issue: issues=%0d required req1 issued at C+5",
                     iss_q.size());
        end
        tests++;
        if (busy_drop !== 1'b0) begin
            fails++;
            $display("FAIL late_busy: busy dropped=%b required 0", busy_drop);
        end
        tests++;
        if (rsp_q.size() != 2 || rsp_q[1].res !== exp_res[1] || rsp_q[1].id !== 2'd1) begin
            fails++;
            $display("FAIL late_rsp: rsps=%0d required 2nd result %h id 1",
                     rsp_q.size(), exp_res[1]);
        end
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL late_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int order [5];
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        auto_drop = 1'b0;
        iss_q.delete();
        rsp_q.delete();
        req = 4'b1111;
        for (int k = 0; k < 40 && iss_q.size() < 5; k++) step();
        req = '0;
        for (int k = 0; k < 20 && rsp_q.size() < 5; k++) step();
        step();
        step();
        tests++;
        if (iss_q.size() != 5 || rsp_q.size() != 5) begin
            fails++;
            $display("FAIL rr_count: issues=%0d rsps=%0d required 5 and 5",
                     iss_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (iss_q[i].gnt !== (4'b0001 << order[i]) ||
                    iss_q[i].a !== a_v[order[i]] || iss_q[i].b !== b_v[order[i]] ||
                    iss_q[i].op !== op_v[order[i]] ||
                    (i > 0 && iss_q[i].cyc != iss_q[i-1].cyc + 5)) begin
                    fails++;
                    $display("FAIL rr_issue%0d: gnt=%b required %b spaced 5",
                             i, iss_q[i].gnt, 4'b0001 << order[i]);
                end
                tests++;
                if (rsp_q[i].v !== (4'b0001 << order[i]) ||
                    rsp_q[i].res !== exp_res[order[i]] ||
                    rsp_q[i].cyc != iss_q[i].cyc + 4) begin
                    fails++;
                    $display("FAIL rr_rsp%0d: res=%h required %h",
                             i, rsp_q[i].res, exp_res[order[i]]);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        auto_drop = 1'b0;
        fixed_en = 1'b0;
        req = '0;
        rst_n = 1'b1;
        set_table();
        test_reset();
        test_single();
        test_wrap_skip();
        test_withdrawal();
        test_late_arrival();
        test_round_robin();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
